// File: rtl/scalar_seq_ctrl_pkg.sv
// Shared definitions for the scalar sequencer: opcodes, PE_scalar operation
// codes, FSM state encoding and instruction field offsets.
package scalar_seq_ctrl_pkg;

  // Controller opcodes; 011..110 are treated as NOPs.
  localparam logic [2:0] OP_LUI  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Operation codes understood by PE_scalar.
  localparam logic [2:0] PE_OP_NONE  = 3'b000;
  localparam logic [2:0] PE_OP_ADDI  = 3'b001;
  localparam logic [2:0] PE_OP_CMPEQ = 3'b010;

  // Instruction word is {op, rd, rs1, rs2, imm}. The register and opcode
  // fields sit above the data-width immediate, so these offsets are added
  // to the immediate width to find each field.
  localparam int FIELD_W = 3;
  localparam int OP_OFS  = 9;
  localparam int RD_OFS  = 6;
  localparam int RS1_OFS = 3;
  localparam int RS2_OFS = 0;

  localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/scalar_seq_ctrl_pe.sv
// PE_scalar: combinational scalar datapath shared with the controller.
// Performs immediate add and equality compare; idle op yields zeros.
module PE_scalar
  import scalar_seq_ctrl_pkg::*;
#(
  parameter int dwidth_int = 32
) (
  input  logic [dwidth_int-1:0] inp1,
  input  logic [dwidth_int-1:0] inp2,
  input  logic [dwidth_int-1:0] R_immediate,
  input  logic [2:0]            op_scalar,
  output logic [dwidth_int-1:0] out1,
  output logic                  flag_eq
);

  // Decode the requested operation; results are zero unless selected.
  always_comb begin
    out1    = '0;
    flag_eq = 1'b0;
    case (op_scalar)
      PE_OP_ADDI:  out1    = inp1 + R_immediate;
      PE_OP_CMPEQ: flag_eq = (inp1 == inp2);
      default: ;
    endcase
  end

endmodule

// File: rtl/scalar_seq_ctrl.sv
// scalar_seq_ctrl: tiny in-order sequencer that fetches one instruction per
// cycle from an inline instruction memory and executes it against an inline
// register file, using a single PE_scalar for add and compare.
module scalar_seq_ctrl
  import scalar_seq_ctrl_pkg::*;
#(
  parameter int dwidth_int = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int NREG       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [12+dwidth_int-1:0]      prog_wdata,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [15:0]                   retired,
  input  logic [2:0]                    rf_raddr,
  output logic [dwidth_int-1:0]         rf_rdata
);

  localparam int PCW = $clog2(IMEM_DEPTH);
  localparam int IW  = 12 + dwidth_int;

  logic [IW-1:0]         imem_q [IMEM_DEPTH];
  logic [dwidth_int-1:0] rf_q   [NREG];

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [15:0]     retired_q, retired_d;

  logic [IW-1:0]         instr;
  logic [2:0]            op, rd, rs1, rs2;
  logic [dwidth_int-1:0] imm, rs1Data, rs2Data;
  logic [PCW-1:0]        pcInc;

  logic                  rfWe;
  logic [dwidth_int-1:0] rfWdata;
  logic [2:0]            peOp;
  logic [dwidth_int-1:0] peOut;
  logic                  peFlagEq;

  assign instr   = imem_q[pc_q];
  assign op      = instr[dwidth_int+OP_OFS  +: FIELD_W];
  assign rd      = instr[dwidth_int+RD_OFS  +: FIELD_W];
  assign rs1     = instr[dwidth_int+RS1_OFS +: FIELD_W];
  assign rs2     = instr[dwidth_int+RS2_OFS +: FIELD_W];
  assign imm     = instr[dwidth_int-1:0];
  assign rs1Data = rf_q[rs1];
  assign rs2Data = rf_q[rs2];
  assign pcInc   = (pc_q == PCW'(IMEM_DEPTH-1)) ? '0 : pc_q + 1'b1;

  PE_scalar #(.dwidth_int(dwidth_int)) u_pe (
    .inp1        (rs1Data),
    .inp2        (rs2Data),
    .R_immediate (imm),
    .op_scalar   (peOp),
    .out1        (peOut),
    .flag_eq     (peFlagEq)
  );

  // Next-state, PC, retire count and register-write decode for the sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    rfWe      = 1'b0;
    rfWdata   = '0;
    peOp      = PE_OP_NONE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      ST_RUN: begin
        if (retired_q != RETIRED_MAX) retired_d = retired_q + 16'd1;
        pc_d = pcInc;
        case (op)
          OP_LUI: begin
            rfWe    = 1'b1;
            rfWdata = imm;
          end
          OP_ADDI: begin
            peOp    = PE_OP_ADDI;
            rfWe    = 1'b1;
            rfWdata = peOut;
          end
          OP_BEQ: begin
            peOp = PE_OP_CMPEQ;
            if (peFlagEq) pc_d = imm[PCW-1:0];
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = ST_DONE;
          end
          default: ;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural state; reset aborts any instruction on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      if (rfWe) rf_q[rd] <= rfWdata;
    end
  end

  // Program loading is locked out while running; memory survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q != ST_RUN)) imem_q[prog_addr] <= prog_wdata;
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign rf_rdata = rf_q[rf_raddr];

endmodule

// File: tb/tb_scalar_seq_ctrl.sv
// Self-checking bench for scalar_seq_ctrl: directed programs, a vector table
// of single-instruction cases and random programs against an ISA model.
module tb_scalar_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [43:0] prog_wdata;
  logic        start;
  logic        busy, done;
  logic [3:0]  pc;
  logic [15:0] retired;
  logic [2:0]  rf_raddr;
  logic [31:0] rf_rdata;

  int assertCount = 0;
  int failCount   = 0;

  logic [43:0] modelMem  [16];
  logic [31:0] modelRegs [8];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] imm;
    logic [31:0] expR3;
    int          expRetired;
  } vec_t;

  vec_t vecs [7];

  scalar_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .retired    (retired),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [43:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [31:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) modelRegs[i] = '0;
  endtask

  task automatic writeMem(input int addr, input logic [43:0] word);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = 4'(addr);
    prog_wdata = word;
    modelMem[addr] = word;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic readReg(input int idx, output logic [31:0] val);
    rf_raddr = 3'(idx);
    #1;
    val = rf_rdata;
  endtask

  // Pulse start, then count busy cycles and done pulses until done is seen.
  task automatic applyStimulus(input int budget, output int busyCnt, output int doneCnt);
    bit timedOut;
    busyCnt  = 0;
    doneCnt  = 0;
    timedOut = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        timedOut = 1'b0;
        @(negedge clk);
        if (done) doneCnt++;
        break;
      end
      @(negedge clk);
    end
    checkOutput("run_timeout", 64'(timedOut), 64'd0);
  endtask

  // Instruction-set interpreter over the bench's copy of program and registers.
  task automatic modelRun(input int budget, output int retiredM, output int pcM);
    int p = 0;
    bit halted = 1'b0;
    logic [43:0] w;
    logic [2:0]  op, rd, rs1, rs2;
    logic [31:0] imm;
    retiredM = 0;
    for (int s = 0; s < budget && !halted; s++) begin
      w   = modelMem[p];
      op  = w[43:41];
      rd  = w[40:38];
      rs1 = w[37:35];
      rs2 = w[34:32];
      imm = w[31:0];
      if (retiredM < 65535) retiredM++;
      case (op)
        3'd0: begin modelRegs[rd] = imm; p = (p + 1) % 16; end
        3'd1: begin modelRegs[rd] = modelRegs[rs1] + imm; p = (p + 1) % 16; end
        3'd2: p = (modelRegs[rs1] == modelRegs[rs2]) ? int'(imm % 16) : (p + 1) % 16;
        3'd7: halted = 1'b1;
        default: p = (p + 1) % 16;
      endcase
    end
    pcM = p;
  endtask

  initial begin
    int          busyCnt, doneCnt, retM, pcM, r, tgt;
    logic [31:0] v, tmp, immv;
    logic [2:0]  opv;

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; rf_raddr = '0;
    for (int i = 0; i < 16; i++) modelMem[i] = '0;
    for (int i = 0; i < 8; i++) modelRegs[i] = '0;

    vecs[0] = '{"lui",       32'd5,          32'd7, 3'd0, 32'h1234, 32'h1234, 4};
    vecs[1] = '{"addi",      32'h10,         32'd7, 3'd1, 32'h22,   32'h32,   4};
    vecs[2] = '{"addi_wrap", 32'hFFFF_FFFE,  32'd7, 3'd1, 32'd3,    32'd1,    4};
    vecs[3] = '{"beq_taken", 32'd9,          32'd9, 3'd2, 32'd5,    32'h77,   5};
    vecs[4] = '{"beq_not",   32'd9,          32'd8, 3'd2, 32'd5,    32'd0,    4};
    vecs[5] = '{"nop",       32'd9,          32'd8, 3'd5, 32'd5,    32'd0,    4};
    vecs[6] = '{"halt",      32'd9,          32'd8, 3'd7, 32'd5,    32'd0,    3};

    // Reset state.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pc", 64'(pc), 64'd0);
    checkOutput("rst_retired", 64'(retired), 64'd0);
    readReg(2, v);
    checkOutput("rst_r2", 64'(v), 64'd0);

    // Basic program: LUI R1,5; ADDI R2,R1,3; HALT.
    writeMem(0, enc(3'd0, 3'd1, 3'd0, 3'd0, 32'd5));
    writeMem(1, enc(3'd1, 3'd2, 3'd1, 3'd0, 32'd3));
    writeMem(2, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
    applyStimulus(50, busyCnt, doneCnt);
    readReg(2, v);
    checkOutput("basic_r2", 64'(v), 64'd8);
    readReg(1, v);
    checkOutput("basic_r1", 64'(v), 64'd5);
    checkOutput("basic_retired", 64'(retired), 64'd3);
    checkOutput("basic_done_pulses", 64'(doneCnt), 64'd1);
    checkOutput("basic_busy_cycles", 64'(busyCnt), 64'd3);
    checkOutput("basic_pc_halt", 64'(pc), 64'd2);

    // Counting loop.
    doReset();
    writeMem(0, enc(3'd0, 3'd1, 3'd0, 3'd0, 32'd0));
    writeMem(1, enc(3'd0, 3'd3, 3'd0, 3'd0, 32'd4));
    writeMem(2, enc(3'd1, 3'd1, 3'd1, 3'd0, 32'd1));
    writeMem(3, enc(3'd2, 3'd0, 3'd1, 3'd3, 32'd5));
    writeMem(4, enc(3'd2, 3'd0, 3'd0, 3'd0, 32'd2));
    writeMem(5, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
    applyStimulus(100, busyCnt, doneCnt);
    readReg(1, v);
    checkOutput("loop_r1", 64'(v), 64'd4);
    checkOutput("loop_retired", 64'(retired), 64'd14);
    checkOutput("loop_busy_cycles", 64'(busyCnt), 64'd14);

    // Add wraps modulo 2^32.
    writeMem(0, enc(3'd0, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF));
    writeMem(1, enc(3'd1, 3'd1, 3'd1, 3'd0, 32'd1));
    writeMem(2, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
    applyStimulus(50, busyCnt, doneCnt);
    readReg(1, v);
    checkOutput("wrap_r1", 64'(v), 64'd0);
    checkOutput("wrap_retired", 64'(retired), 64'd3);

    // Vector table: LUI R1,a; LUI R2,b; <op R3,R1,R2,imm>; HALT; HALT; LUI R3,0x77; HALT.
    for (int t = 0; t < 7; t++) begin
      doReset();
      writeMem(0, enc(3'd0, 3'd1, 3'd0, 3'd0, vecs[t].a));
      writeMem(1, enc(3'd0, 3'd2, 3'd0, 3'd0, vecs[t].b));
      writeMem(2, enc(vecs[t].op, 3'd3, 3'd1, 3'd2, vecs[t].imm));
      writeMem(3, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
      writeMem(4, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
      writeMem(5, enc(3'd0, 3'd3, 3'd0, 3'd0, 32'h77));
      writeMem(6, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
      applyStimulus(50, busyCnt, doneCnt);
      readReg(3, v);
      checkOutput({"vec_", vecs[t].name, "_r3"}, 64'(v), 64'(vecs[t].expR3));
      checkOutput({"vec_", vecs[t].name, "_retired"}, 64'(retired), 64'(vecs[t].expRetired));
    end

    // Sixteen NOPs: pc wraps from 15 back to 0 while still running.
    doReset();
    for (int a = 0; a < 16; a++) writeMem(a, enc(3'd3, 3'd0, 3'd0, 3'd0, 32'd0));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      if (k >= 16) checkOutput($sformatf("nop_wrap_pc_k%0d", k), 64'(pc), 64'((k - 1) % 16));
      if (k == 18) begin
        checkOutput("nop_wrap_retired", 64'(retired), 64'd17);
        checkOutput("nop_wrap_busy", 64'(busy), 64'd1);
      end
      @(negedge clk);
    end
    doReset();

    // Write and start together in IDLE: HALT lands at 0 before the first fetch.
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd0; start = 1'b1;
    prog_wdata = enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0);
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    checkOutput("wstart_busy", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("wstart_done", 64'(done), 64'd1);
    checkOutput("wstart_retired", 64'(retired), 64'd1);
    checkOutput("wstart_pc", 64'(pc), 64'd0);
    @(negedge clk);

    // Restart and program writes ignored during RUN; reset aborts mid-program.
    writeMem(0, enc(3'd0, 3'd1, 3'd0, 3'd0, 32'd9));
    for (int a = 1; a < 15; a++) writeMem(a, enc(3'd1, 3'd1, 3'd1, 3'd0, 32'd1));
    writeMem(15, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_pc_before", 64'(pc), 64'd2);
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd15;
    prog_wdata = enc(3'd0, 3'd5, 3'd0, 3'd0, 32'hDEAD);
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    checkOutput("abort_restart_ignored_pc", 64'(pc), 64'd3);
    checkOutput("abort_retired", 64'(retired), 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) modelRegs[i] = '0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_pc", 64'(pc), 64'd0);
    checkOutput("abort_retired_clr", 64'(retired), 64'd0);
    readReg(1, v);
    checkOutput("abort_r1", 64'(v), 64'd0);
    applyStimulus(50, busyCnt, doneCnt);
    readReg(1, v);
    checkOutput("abort_rerun_r1", 64'(v), 64'd23);
    readReg(5, v);
    checkOutput("abort_rerun_r5", 64'(v), 64'd0);
    checkOutput("abort_rerun_retired", 64'(retired), 64'd16);

    // Random forward-branching programs against the ISA model.
    doReset();
    for (int n = 0; n < 12; n++) begin
      for (int a = 0; a < 15; a++) begin
        r   = int'($urandom_range(0, 9));
        tmp = $urandom();
        if (r <= 2) begin
          opv  = 3'd0;
          immv = (tmp[0]) ? 32'($urandom_range(0, 3)) : $urandom();
        end else if (r <= 5) begin
          opv  = 3'd1;
          immv = (tmp[1]) ? 32'($urandom_range(0, 15)) : $urandom();
        end else if (r <= 7) begin
          opv  = 3'd2;
          tgt  = int'($urandom_range(15, a + 1));
          immv = {tmp[31:4], 4'(tgt)};
        end else begin
          opv  = 3'(3 + (r % 4));
          immv = tmp;
        end
        writeMem(a, enc(opv, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 7)), immv));
      end
      writeMem(15, enc(3'd7, 3'd0, 3'd0, 3'd0, 32'd0));
      modelRun(100, retM, pcM);
      applyStimulus(100, busyCnt, doneCnt);
      checkOutput($sformatf("rnd%0d_retired", n), 64'(retired), 64'(retM));
      checkOutput($sformatf("rnd%0d_busy", n), 64'(busyCnt), 64'(retM));
      checkOutput($sformatf("rnd%0d_done", n), 64'(doneCnt), 64'd1);
      checkOutput($sformatf("rnd%0d_pc", n), 64'(pc), 64'(pcM));
      for (int i = 0; i < 8; i++) begin
        readReg(i, v);
        checkOutput($sformatf("rnd%0d_r%0d", n, i), 64'(v), 64'(modelRegs[i]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
